// File: rtl/softmax_pkg.sv
// Shared types and helpers for the pseudo-softmax datapath.
package softmax_pkg;

    // Default logit width used by the datapath stages.
    localparam int DATA_WIDTH_DEF = 8;

    // Operand width of the signed compare helper; callers sign-extend into it.
    localparam int CMP_W = 32;

    // The max/subtract stage either collects a vector or replays it.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Signed strict greater-than. Ties return 0, so the earliest maximum is kept.
    function automatic logic signed_gt(input logic signed [CMP_W-1:0] a,
                                       input logic signed [CMP_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/softmax_vec_buffer.sv
// Element store for one vector: a single write port and a combinational read port.
// Storage has no reset. Entries are always written before they are read.
module softmax_vec_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int IDX_WIDTH  = $clog2(VEC_LEN)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_WIDTH-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_WIDTH-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [VEC_LEN];

    // Write the accepted element into its slot.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/softmax_max_subtract.sv
// Collects one vector of signed logits, tracks its maximum, then replays
// each element as the unsigned offset (max - x_i) together with its index.
module softmax_max_subtract
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int VEC_LEN    = 8,
    parameter int IDX_WIDTH  = $clog2(VEC_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] vec_max
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VEC_LEN - 1);

    state_e                        r_state;
    state_e                        w_next_state;
    logic                          r_in_ready;
    logic [IDX_WIDTH-1:0]          r_wr_cnt;
    logic [IDX_WIDTH-1:0]          r_rd_cnt;
    logic signed [DATA_WIDTH-1:0]  r_max;

    logic signed [DATA_WIDTH-1:0]  w_in_s;
    logic [DATA_WIDTH-1:0]         w_rd_data;
    logic [DATA_WIDTH:0]           w_diff;
    logic                          w_accept;
    logic                          w_out_fire;
    logic                          w_wr_last;
    logic                          w_rd_last;
    logic                          w_new_max;

    assign w_in_s     = in_data;
    assign w_accept   = in_valid && r_in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_wr_last  = (r_wr_cnt == LAST_IDX);
    assign w_rd_last  = (r_rd_cnt == LAST_IDX);
    assign w_new_max  = signed_gt(CMP_W'(w_in_s), CMP_W'(r_max));

    // Offset taken one bit wider so max - min of the full signed range cannot wrap.
    assign w_diff = {r_max[DATA_WIDTH-1], r_max} - {w_rd_data[DATA_WIDTH-1], w_rd_data};

    softmax_vec_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LEN    (VEC_LEN),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_cnt),
        .i_wdata (in_data),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave FILL on the last accept, leave DRAIN on the last handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_accept && w_wr_last)   w_next_state = DRAIN;
            DRAIN:   if (w_out_fire && w_rd_last) w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
    end

    // Outputs: offsets are presented only while draining, zero otherwise.
    always_comb begin
        out_valid = (r_state == DRAIN);
        out_data  = out_valid ? w_diff[DATA_WIDTH-1:0] : '0;
        out_idx   = out_valid ? r_rd_cnt : '0;
        out_last  = out_valid && w_rd_last;
        vec_max   = r_max;
    end

    assign in_ready = r_in_ready;

    // in_ready is registered; it stays low for the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == FILL);
        end
    end

    // Write counter and running maximum; the first element seeds the max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_max    <= '0;
        end else if (w_accept) begin
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + IDX_WIDTH'(1);
            if (r_wr_cnt == '0 || w_new_max) begin
                r_max <= w_in_s;
            end
        end
    end

    // Read counter advances on each downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
        end else if (w_out_fire) begin
            r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + IDX_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_softmax_max_subtract.sv
// Scoreboard bench for softmax_max_subtract with VEC_LEN=4, DATA_WIDTH=8.
module tb_softmax_max_subtract;

    localparam int DW = 8;
    localparam int VL = 4;
    localparam int IW = 2;

    typedef struct {
        int data;
        int idx;
        int last;
        int vmax;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic [DW-1:0] vec_max;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   bp_mode = 1'b0;

    softmax_max_subtract #(.DATA_WIDTH(DW), .VEC_LEN(VL), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .vec_max   (vec_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always 1, or random when back-pressure is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stall stability.
    initial begin
        bit   prev_stall = 1'b0;
        int   p_data = 0, p_idx = 0, p_last = 0, p_vmax = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), p_data);
                chk("stall_idx", int'(out_idx), p_idx);
                chk("stall_last", int'(out_last), p_last);
                chk("stall_vmax", int'(vec_max), p_vmax);
            end
            if (out_valid) begin
                chk("in_ready_in_drain", int'(in_ready), 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got idx %0d data %0d expected none", out_idx, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        chk("out_idx", int'(out_idx), e.idx);
                        chk("out_last", int'(out_last), e.last);
                        chk("vec_max", int'(vec_max), e.vmax);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            p_data = int'(out_data);
            p_idx  = int'(out_idx);
            p_last = int'(out_last);
            p_vmax = int'(vec_max);
        end
    end

    // Reference: max over the vector, offsets by plain integer subtraction.
    task automatic model(input int v[VL]);
        int   mx;
        exp_t e;
        mx = v[0];
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        foreach (v[i]) begin
            e.data = mx - v[i];
            e.idx  = i;
            e.last = (i == VL - 1) ? 1 : 0;
            e.vmax = mx & 255;
            exp_q.push_back(e);
        end
    endtask

    // Feed one vector; optionally random gaps, in_valid held during drain, wait for drain.
    task automatic send_vec(input int v[VL], input int gap_max, input bit hold_valid,
                            input bit wait_drain);
        int t;
        bit acc;
        model(v);
        for (int i = 0; i < VL; i++) begin
            if (gap_max > 0) begin
                int g = $urandom_range(0, gap_max);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = 8'(v[i]);
            t = 0;
            forever begin
                acc = in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                if (++t > 50) begin
                    chk("accept_timeout", 0, 1);
                    break;
                end
            end
        end
        chk("first_out_latency", int'(out_valid), 1);
        in_valid = hold_valid;
        in_data  = 8'($urandom);
        if (wait_drain) begin
            t = 0;
            while (exp_q.size() != 0 || out_valid) begin
                @(posedge clk);
                #1;
                if (++t > 300) begin
                    chk("drain_timeout", 0, 1);
                    break;
                end
            end
            in_valid = 1'b0;
            chk("in_ready_after_drain", int'(in_ready), 1);
            chk("queue_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        int v[VL];
        int t;

        // Reset values before any clock edge.
        #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_vec_max", int'(vec_max), 0);
        #10;
        rst_n = 1'b1;
        #2;
        chk("in_ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_first_edge", int'(in_ready), 1);

        // Directed vectors: basic, extremes, all-negative with ties.
        v = '{5, -3, 20, 20};
        send_vec(v, 0, 1'b0, 1'b1);
        chk("vec_max_hold_fill", int'(vec_max), 20);
        v = '{-128, 127, 0, -1};
        send_vec(v, 0, 1'b0, 1'b1);
        v = '{-7, -7, -100, -8};
        send_vec(v, 0, 1'b0, 1'b1);

        // Back-pressure with in_valid held high during drain.
        bp_mode = 1'b1;
        v = '{10, -50, 33, 33};
        send_vec(v, 0, 1'b1, 1'b1);

        // Random vectors with input gaps and back-pressure.
        for (int n = 0; n < 25; n++) begin
            foreach (v[i]) v[i] = $signed(8'($urandom));
            send_vec(v, (n % 2) * 3, n[2], 1'b1);
        end

        // Async reset while element 2 is presented.
        bp_mode = 1'b0;
        v = '{40, 0, -40, 7};
        send_vec(v, 0, 1'b0, 1'b0);
        t = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_idx == 2'd2) break;
            if (++t > 50) begin
                chk("reach_idx2_timeout", 0, 1);
                break;
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_data", int'(out_data), 0);
        exp_q.delete();
        @(negedge clk);
        chk("rst_hold_in_ready", int'(in_ready), 0);
        chk("rst_hold_out_valid", int'(out_valid), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        chk("no_stale_output", int'(out_valid), 0);
        v = '{1, 2, 3, 4};
        send_vec(v, 0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
